// File: rtl/RV32I_definitions.sv
// RV32I_definitions: shared types for the fetch unit and its branch target buffer.
package RV32I_definitions;

   typedef enum logic [1:0] {
      STRONG_NT = 2'd0,
      WEAK_NT   = 2'd1,
      WEAK_T    = 2'd2,
      STRONG_T  = 2'd3
   } btb_ctr_t;

   localparam btb_ctr_t BTB_CTR_ALLOC = WEAK_T;

   // Saturating step of a 2-bit predictor counter toward taken (up=1) or not taken.
   function automatic btb_ctr_t ctr_step(input btb_ctr_t c, input logic up);
      return up ? ((c == STRONG_T) ? STRONG_T : btb_ctr_t'(c + 2'd1))
                : ((c == STRONG_NT) ? STRONG_NT : btb_ctr_t'(c - 2'd1));
   endfunction

endpackage

// File: rtl/if_btb.sv
// if_btb: direct-mapped branch target buffer with 2-bit counters.
// Only the valid bits are reset; the data array is left uninitialised.
module if_btb
   import RV32I_definitions::*;
#(
   parameter int XLEN      = 32,
   parameter int BTB_DEPTH = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_lkp_pc,
   output logic            o_pred_taken,
   output logic [XLEN-1:0] o_pred_target,
   input  logic            i_upd_valid,
   input  logic [XLEN-1:0] i_upd_pc,
   input  logic [XLEN-1:0] i_upd_target,
   input  logic            i_upd_taken
);
   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = XLEN - 2 - IDX_W;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      btb_ctr_t         ctr;
   } btb_entry_t;

   logic [BTB_DEPTH-1:0] r_valid;
   btb_entry_t           r_data [BTB_DEPTH];
   logic [IDX_W-1:0]     w_lidx, w_uidx;
   btb_entry_t           w_lent, w_uent, w_wdata;
   logic                 w_lhit, w_uhit, w_unused;

   assign w_lidx        = i_lkp_pc[IDX_W+1:2];
   assign w_lent        = r_data[w_lidx];
   assign w_lhit        = r_valid[w_lidx] && (w_lent.tag == i_lkp_pc[XLEN-1:IDX_W+2]) && (i_lkp_pc[1:0] == 2'b00);
   assign o_pred_taken  = w_lhit & w_lent.ctr[1];
   assign o_pred_target = o_pred_taken ? w_lent.target : '0;

   assign w_uidx   = i_upd_pc[IDX_W+1:2];
   assign w_uent   = r_data[w_uidx];
   assign w_uhit   = r_valid[w_uidx] && (w_uent.tag == i_upd_pc[XLEN-1:IDX_W+2]);
   assign w_unused = ^i_upd_pc[1:0];

   always_comb begin
      w_wdata        = w_uent;
      w_wdata.ctr    = w_uhit ? ctr_step(w_uent.ctr, i_upd_taken) : BTB_CTR_ALLOC;
      w_wdata.target = i_upd_taken ? i_upd_target : w_uent.target;
      w_wdata.tag    = i_upd_pc[XLEN-1:IDX_W+2];
   end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst)
         r_valid <= '0;
      else if (i_upd_valid && i_upd_taken && !w_uhit)
         r_valid[w_uidx] <= 1'b1;

   // A not-taken miss leaves the slot alone; every other update rewrites it.
   always_ff @(posedge i_clk)
      if (i_upd_valid && (w_uhit || i_upd_taken))
         r_data[w_uidx] <= w_wdata;

endmodule

// File: rtl/if_pc_predict.sv
// if_pc_predict: fetch PC register with prioritised redirects, stall and BTB prediction.
module if_pc_predict #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              BTB_DEPTH    = 16
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            PC_Stall,
   input  logic            Trap_Redirect,
   input  logic [XLEN-1:0] Trap_Vector,
   input  logic            EX_PC_Branch,
   input  logic [XLEN-1:0] EX_PC_Branch_dest,
   input  logic            ID_Jump,
   input  logic [XLEN-1:0] ID_PC_dest,
   input  logic            EX_Upd_Valid,
   input  logic [XLEN-1:0] EX_Upd_PC,
   input  logic [XLEN-1:0] EX_Upd_Target,
   input  logic            EX_Upd_Taken,
   output logic [XLEN-1:0] PC_Out,
   output logic            PC_Pred_Taken,
   output logic [XLEN-1:0] PC_Pred_Target,
   output logic            PC_Misaligned
);
   logic [XLEN-1:0] r_pc, w_next;

   if_btb #(.XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH)) u_btb (
      .i_clk         (Clk),
      .i_rst         (Reset),
      .i_lkp_pc      (r_pc),
      .o_pred_taken  (PC_Pred_Taken),
      .o_pred_target (PC_Pred_Target),
      .i_upd_valid   (EX_Upd_Valid),
      .i_upd_pc      (EX_Upd_PC),
      .i_upd_target  (EX_Upd_Target),
      .i_upd_taken   (EX_Upd_Taken)
   );

   // Flushes outrank the hazard stall; prediction only applies to a free-running fetch.
   always_comb
      w_next = Trap_Redirect ? Trap_Vector :
               EX_PC_Branch  ? EX_PC_Branch_dest :
               ID_Jump       ? ID_PC_dest :
               PC_Stall      ? r_pc :
               PC_Pred_Taken ? PC_Pred_Target : r_pc + XLEN'(4);

   always_ff @(posedge Clk or posedge Reset)
      if (Reset)
         r_pc <= RESET_VECTOR;
      else
         r_pc <= w_next;

   assign PC_Out        = r_pc;
   assign PC_Misaligned = |r_pc[1:0];

endmodule

// File: tb/tb_if_pc_predict.sv
// tb_if_pc_predict: directed and randomized checks of if_pc_predict against a behavioural model.
module tb_if_pc_predict;
   logic        Clk, Reset, PC_Stall, Trap_Redirect, EX_PC_Branch, ID_Jump;
   logic        EX_Upd_Valid, EX_Upd_Taken;
   logic [31:0] Trap_Vector, EX_PC_Branch_dest, ID_PC_dest, EX_Upd_PC, EX_Upd_Target;
   logic [31:0] PC_Out, PC_Pred_Target;
   logic        PC_Pred_Taken, PC_Misaligned;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] m_pc;
   bit          m_valid [16];
   logic [31:0] m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_ctr [16];

   if_pc_predict #(.XLEN(32), .RESET_VECTOR(32'h100), .BTB_DEPTH(16)) dut (
      .Clk(Clk), .Reset(Reset), .PC_Stall(PC_Stall),
      .Trap_Redirect(Trap_Redirect), .Trap_Vector(Trap_Vector),
      .EX_PC_Branch(EX_PC_Branch), .EX_PC_Branch_dest(EX_PC_Branch_dest),
      .ID_Jump(ID_Jump), .ID_PC_dest(ID_PC_dest),
      .EX_Upd_Valid(EX_Upd_Valid), .EX_Upd_PC(EX_Upd_PC),
      .EX_Upd_Target(EX_Upd_Target), .EX_Upd_Taken(EX_Upd_Taken),
      .PC_Out(PC_Out), .PC_Pred_Taken(PC_Pred_Taken),
      .PC_Pred_Target(PC_Pred_Target), .PC_Misaligned(PC_Misaligned)
   );

   initial begin
      Clk = 0;
      forever #5 Clk = ~Clk;
   end

   task automatic model_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
      int i;
      i  = int'((pc / 4) % 16);
      tk = m_valid[i] && (m_tag[i] == pc / 64) && (pc % 4 == 0) && (m_ctr[i] >= 2);
      tg = tk ? m_tgt[i] : 32'h0;
   endtask

   task automatic clear_inputs();
      {PC_Stall, Trap_Redirect, EX_PC_Branch, ID_Jump, EX_Upd_Valid, EX_Upd_Taken} = '0;
      {Trap_Vector, EX_PC_Branch_dest, ID_PC_dest, EX_Upd_PC, EX_Upd_Target} = '0;
   endtask

   task automatic tick();
      logic        tk;
      logic [31:0] tg, nx;
      int          i;
      model_pred(m_pc, tk, tg);
      if (Trap_Redirect)     nx = Trap_Vector;
      else if (EX_PC_Branch) nx = EX_PC_Branch_dest;
      else if (ID_Jump)      nx = ID_PC_dest;
      else if (PC_Stall)     nx = m_pc;
      else if (tk)           nx = tg;
      else                   nx = m_pc + 32'd4;
      i = int'((EX_Upd_PC / 4) % 16);
      if (EX_Upd_Valid) begin
         if (m_valid[i] && m_tag[i] == EX_Upd_PC / 64) begin
            if (EX_Upd_Taken) begin
               m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               m_tgt[i] = EX_Upd_Target;
            end else
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end else if (EX_Upd_Taken) begin
            m_valid[i] = 1;
            m_tag[i]   = EX_Upd_PC / 64;
            m_tgt[i]   = EX_Upd_Target;
            m_ctr[i]   = 2;
         end
      end
      @(posedge Clk);
      #1;
      m_pc = nx;
   endtask

   task automatic goto_pc(input logic [31:0] a);
      EX_PC_Branch = 1; EX_PC_Branch_dest = a;
      tick();
      EX_PC_Branch = 0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      EX_Upd_Valid = 1; EX_Upd_PC = pc; EX_Upd_Taken = tk; EX_Upd_Target = tg;
      tick();
      EX_Upd_Valid = 0; EX_Upd_Taken = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      Reset = 0;
      #2;
      Reset = 1;
      #1;
      m_pc = 32'h100;
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      n_chk++; if (PC_Out !== 32'h100) begin n_fail++; $display("FAIL reset_pc got %h exp %h", PC_Out, 32'h100); end
      n_chk++; if (PC_Pred_Taken !== 1'b0 || PC_Pred_Target !== 32'h0) begin n_fail++; $display("FAIL reset_pred got %b/%h exp 0/0", PC_Pred_Taken, PC_Pred_Target); end
      n_chk++; if (PC_Misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misal got %b exp 0", PC_Misaligned); end
      @(posedge Clk);
      #1;
      Reset = 0;
   endtask

   task automatic test_seq();
      logic [31:0] exp_pc [3] = '{32'h104, 32'h108, 32'h10C};
      for (int k = 0; k < 3; k++) begin
         tick();
         n_chk++; if (PC_Out !== exp_pc[k] || PC_Out !== m_pc) begin n_fail++; $display("FAIL seq_%0d got %h exp %h", k, PC_Out, exp_pc[k]); end
      end
   endtask

   task automatic test_priority();
      logic [31:0] exp_pc [4] = '{32'h80, 32'h200, 32'h300, 32'h300};
      Trap_Redirect = 1; Trap_Vector = 32'h80;
      EX_PC_Branch = 1; EX_PC_Branch_dest = 32'h200;
      ID_Jump = 1; ID_PC_dest = 32'h300;
      PC_Stall = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_chk++; if (PC_Out !== exp_pc[k] || PC_Out !== m_pc) begin n_fail++; $display("FAIL prio_%0d got %h exp %h", k, PC_Out, exp_pc[k]); end
         if (k == 0) Trap_Redirect = 0;
         if (k == 1) EX_PC_Branch = 0;
         if (k == 2) ID_Jump = 0;
      end
      PC_Stall = 0;
   endtask

   task automatic test_alloc();
      upd(32'h40, 1, 32'h400);
      goto_pc(32'h40);
      n_chk++; if (PC_Pred_Taken !== 1'b1 || PC_Pred_Target !== 32'h400) begin n_fail++; $display("FAIL alloc_pred got %b/%h exp 1/00000400", PC_Pred_Taken, PC_Pred_Target); end
      tick();
      n_chk++; if (PC_Out !== 32'h400 || PC_Out !== m_pc) begin n_fail++; $display("FAIL alloc_next got %h exp %h", PC_Out, 32'h400); end
   endtask

   task automatic test_hysteresis();
      logic exp_tk [3] = '{1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 3; k++) begin
         if (k == 0) upd(32'h40, 0, 32'h0);
         if (k == 1) begin upd(32'h40, 1, 32'h440); upd(32'h40, 1, 32'h440); end
         if (k == 2) upd(32'h40, 0, 32'h0);
         goto_pc(32'h40);
         n_chk++; if (PC_Pred_Taken !== exp_tk[k]) begin n_fail++; $display("FAIL hyst_%0d pred got %b exp %b", k, PC_Pred_Taken, exp_tk[k]); end
      end
      n_chk++; if (PC_Pred_Target !== 32'h440) begin n_fail++; $display("FAIL hyst_target got %h exp %h", PC_Pred_Target, 32'h440); end
   endtask

   task automatic test_alias();
      goto_pc(32'h80);
      n_chk++; if (PC_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL alias_miss got %b exp 0", PC_Pred_Taken); end
      upd(32'h80, 1, 32'h800);
      goto_pc(32'h40);
      n_chk++; if (PC_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL alias_evicted got %b exp 0", PC_Pred_Taken); end
      goto_pc(32'h80);
      n_chk++; if (PC_Pred_Taken !== 1'b1 || PC_Pred_Target !== 32'h800) begin n_fail++; $display("FAIL alias_new got %b/%h exp 1/00000800", PC_Pred_Taken, PC_Pred_Target); end
   endtask

   task automatic test_same_cycle();
      goto_pc(32'h1C0);
      EX_Upd_Valid = 1; EX_Upd_PC = 32'h1C0; EX_Upd_Taken = 1; EX_Upd_Target = 32'h900;
      PC_Stall = 1;
      #1;
      n_chk++; if (PC_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_old got %b exp 0", PC_Pred_Taken); end
      tick();
      EX_Upd_Valid = 0; EX_Upd_Taken = 0; PC_Stall = 0;
      n_chk++; if (PC_Out !== 32'h1C0 || PC_Pred_Taken !== 1'b1 || PC_Pred_Target !== 32'h900) begin n_fail++; $display("FAIL stall_upd got %h/%b/%h exp 000001c0/1/00000900", PC_Out, PC_Pred_Taken, PC_Pred_Target); end
   endtask

   task automatic test_wrap_misalign();
      goto_pc(32'hFFFF_FFFC);
      tick();
      n_chk++; if (PC_Out !== 32'h0 || PC_Out !== m_pc) begin n_fail++; $display("FAIL wrap got %h exp 00000000", PC_Out); end
      upd(32'h200, 1, 32'h900);
      goto_pc(32'h202);
      n_chk++; if (PC_Misaligned !== 1'b1 || PC_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL misal got %b/%b exp 1/0", PC_Misaligned, PC_Pred_Taken); end
      tick();
      n_chk++; if (PC_Out !== 32'h206) begin n_fail++; $display("FAIL misal_next got %h exp 00000206", PC_Out); end
      goto_pc(32'h200);
      n_chk++; if (PC_Pred_Taken !== 1'b1 || PC_Misaligned !== 1'b0) begin n_fail++; $display("FAIL aligned_hit got %b/%b exp 1/0", PC_Pred_Taken, PC_Misaligned); end
   endtask

   task automatic test_reset_midop();
      upd(32'h140, 1, 32'h500);
      EX_Upd_Valid = 1; EX_Upd_PC = 32'h180; EX_Upd_Taken = 1; EX_Upd_Target = 32'h600;
      Reset = 1;
      #1;
      m_pc = 32'h100;
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      n_chk++; if (PC_Out !== 32'h100 || PC_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL midop_reset got %h/%b exp 00000100/0", PC_Out, PC_Pred_Taken); end
      @(posedge Clk);
      #1;
      Reset = 0; EX_Upd_Valid = 0; EX_Upd_Taken = 0;
      goto_pc(32'h180);
      n_chk++; if (PC_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL midop_discard got %b exp 0", PC_Pred_Taken); end
      goto_pc(32'h140);
      n_chk++; if (PC_Pred_Taken !== 1'b0) begin n_fail++; $display("FAIL midop_cleared got %b exp 0", PC_Pred_Taken); end
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 31)) * 4;
      if ($urandom_range(0, 15) == 0) a = a | 32'($urandom_range(1, 3));
      return a;
   endfunction

   task automatic test_random();
      logic        tk;
      logic [31:0] tg;
      for (int k = 0; k < 400; k++) begin
         Trap_Redirect = ($urandom_range(0, 19) == 0); Trap_Vector = rnd_addr();
         EX_PC_Branch = ($urandom_range(0, 7) == 0);   EX_PC_Branch_dest = rnd_addr();
         ID_Jump = ($urandom_range(0, 7) == 0);        ID_PC_dest = rnd_addr();
         PC_Stall = ($urandom_range(0, 5) == 0);
         EX_Upd_Valid = ($urandom_range(0, 2) == 0);
         EX_Upd_PC = 32'h100 + 32'($urandom_range(0, 31)) * 4;
         EX_Upd_Taken = 1'($urandom_range(0, 1));
         EX_Upd_Target = rnd_addr();
         #1;
         model_pred(m_pc, tk, tg);
         n_chk++; if (PC_Pred_Taken !== tk || PC_Pred_Target !== tg || PC_Misaligned !== (m_pc[1:0] != 2'b00)) begin
            n_fail++; $display("FAIL rnd_pred_%0d got %b/%h/%b exp %b/%h/%b", k, PC_Pred_Taken, PC_Pred_Target, PC_Misaligned, tk, tg, m_pc[1:0] != 2'b00);
         end
         tick();
         n_chk++; if (PC_Out !== m_pc) begin n_fail++; $display("FAIL rnd_pc_%0d got %h exp %h", k, PC_Out, m_pc); end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_seq();
      test_priority();
      test_alloc();
      test_hysteresis();
      test_alias();
      test_same_cycle();
      test_wrap_misalign();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
